// File: rtl/msk_tx_pkg.sv
// Shared types and constants for the MSK transmit burst path.
// The CRC helper is used only by builds with MSK_FRAMER_CRC_EN defined.
package msk_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SYNC,
        PAY,
        CRC,
        TAIL
    } tx_state_t;

    localparam logic [15:0] CRC16_POLY        = 16'h1021;
    localparam logic [15:0] CRC16_INIT        = 16'hFFFF;
    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h1ACF_FC1D;

    // One CRC-16/CCITT-FALSE step for a single message bit, MSB-first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/msk_crc16_serial.sv
// Bit-serial CRC-16/CCITT-FALSE register with init and enable.
// Built only when MSK_FRAMER_CRC_EN is defined.
`ifdef MSK_FRAMER_CRC_EN
module msk_crc16_serial
    import msk_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (init) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule
`endif

// File: rtl/msk_burst_framer.sv
// TDMA burst serialiser feeding the MSK modulator: preamble, sync, payload, CRC, tail.
// Define MSK_FRAMER_CRC_EN to append the CRC-16 field after the payload.
module msk_burst_framer
    import msk_tx_pkg::*;
#(
    parameter int          SPB       = 4,
    parameter int          PRE_LEN   = 16,
    parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int          TAIL_LEN  = 8,
    parameter int          MAX_BYTES = 64
) (
    input  logic       clk_25m,
    input  logic       rst,
    input  logic       slot_start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       bit_out,
    output logic       time_slot_flag,
    output logic       busy,
    output logic       underrun
);

    localparam int CNT_W = $clog2(SPB);
    localparam int BC_W  = $clog2(MAX_BYTES + 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       idx;
    logic [30:0]      sh;        // bits still to send after the one on bit_out
    logic [BC_W-1:0]  byte_cnt;
    logic             last_q;
    logic             strobe;
    logic             pay_end;
    logic             fetch;

    assign strobe     = (state != IDLE) && (cnt == CNT_W'(SPB - 1));
    assign pay_end    = last_q || (byte_cnt == BC_W'(MAX_BYTES));
    assign fetch      = strobe && ((state == SYNC && idx == 8'd31) ||
                                   (state == PAY && idx == 8'd7 && !pay_end));
    // Ready is combinational so the FIFO pops in the same cycle the byte is loaded.
    assign byte_ready = fetch && byte_valid;
    assign busy       = (state != IDLE);

`ifdef MSK_FRAMER_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_nxt;

    msk_crc16_serial u_crc (
        .clk   (clk_25m),
        .rst_n (rst),
        .init  (slot_start && state == IDLE),
        .en    (strobe && state == PAY),
        .din   (bit_out),
        .crc   (crc_q)
    );

    // Includes the final payload bit, which the register absorbs on this same strobe.
    always_comb crc_nxt = crc16_step(crc_q, bit_out);
`endif

    always_ff @(posedge clk_25m or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            sh             <= '0;
            byte_cnt       <= '0;
            last_q         <= 1'b0;
            bit_out        <= 1'b0;
            time_slot_flag <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (state == IDLE) begin
                if (slot_start) begin
                    state          <= PRE;
                    cnt            <= '0;
                    idx            <= '0;
                    byte_cnt       <= '0;
                    last_q         <= 1'b0;
                    bit_out        <= 1'b1;
                    time_slot_flag <= 1'b1;
                end
            end else begin
                cnt <= strobe ? '0 : cnt + 1'b1;
                if (strobe) begin
                    idx     <= idx + 8'd1;
                    sh      <= {sh[29:0], 1'b0};
                    bit_out <= sh[30];
                    unique case (state)
                        PRE: begin
                            if (idx == 8'(PRE_LEN - 1)) begin
                                state   <= SYNC;
                                idx     <= '0;
                                sh      <= SYNC_WORD[30:0];
                                bit_out <= SYNC_WORD[31];
                            end else begin
                                bit_out <= idx[0];
                            end
                        end
                        SYNC, PAY: begin
                            if (fetch) begin
                                idx <= '0;
                                if (byte_valid) begin
                                    state    <= PAY;
                                    sh       <= {byte_in[6:0], 24'h000000};
                                    bit_out  <= byte_in[7];
                                    last_q   <= byte_last;
                                    byte_cnt <= byte_cnt + 1'b1;
                                end else begin
                                    state    <= TAIL;
                                    bit_out  <= 1'b0;
                                    underrun <= 1'b1;
                                end
                            end else if (state == PAY && idx == 8'd7) begin
                                idx <= '0;
`ifdef MSK_FRAMER_CRC_EN
                                state   <= CRC;
                                sh      <= {crc_nxt[14:0], 16'h0000};
                                bit_out <= crc_nxt[15];
`else
                                state   <= TAIL;
                                bit_out <= 1'b0;
`endif
                            end
                        end
                        CRC: begin
                            if (idx == 8'd15) begin
                                state   <= TAIL;
                                idx     <= '0;
                                bit_out <= 1'b0;
                            end
                        end
                        TAIL: begin
                            bit_out <= 1'b0;
                            if (idx == 8'(TAIL_LEN - 1)) begin
                                state          <= IDLE;
                                idx            <= '0;
                                time_slot_flag <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
